// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time over req/gnt/rvalid,
// and buffers returned words with their PC in a small FIFO for decode. Branch flush redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_branch_flush,
   input  logic [31:0] i_branch_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_if_valid,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   input  logic        i_id_ready
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_entry_t;

   typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q, pc_d, pend_pc_q;
   logic               run_q;
   if_entry_t          fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               full, fire, push, pop;

   // run_q holds off the first request until one edge after reset release
   assign full        = (count_q == CNT_W'(FIFO_DEPTH));
   assign o_imem_req  = run_q && (state_q == REQ) && !full;
   assign o_imem_addr = pc_q;
   assign fire        = o_imem_req && i_imem_gnt;
   assign push        = (state_q == WAIT) && i_imem_rvalid && !i_branch_flush;
   assign o_if_valid  = (count_q != '0);
   assign pop         = o_if_valid && i_id_ready && !i_branch_flush;
   assign o_if_instr  = fifo_q[rd_ptr_q].instr;
   assign o_if_pc     = fifo_q[rd_ptr_q].pc;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         REQ:  if (fire) state_d = i_branch_flush ? DROP : WAIT;
         WAIT: if (i_imem_rvalid) state_d = REQ;
               else if (i_branch_flush) state_d = DROP;
         DROP: if (i_imem_rvalid) state_d = REQ;
         default: state_d = REQ;
      endcase
      // a flush wins over the increment of a same-cycle grant
      if (i_branch_flush)
         pc_d = i_branch_pc & ~32'h3;
      else if (fire)
         pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= REQ;
         pc_q      <= RESET_PC;
         pend_pc_q <= '0;
         run_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         run_q   <= 1'b1;
         if (fire) pend_pc_q <= pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else if (i_branch_flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: pend_pc_q, instr: i_imem_rdata};
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays instruction memory and keeps a
// transaction-level model (expected PC, outstanding fetch, decode queue) to check against.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] K        = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_branch_flush, i_imem_gnt, i_imem_rvalid, i_id_ready;
   logic [31:0] i_branch_pc, i_imem_rdata;
   logic        o_imem_req, o_if_valid;
   logic [31:0] o_imem_addr, o_if_instr, o_if_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_branch_flush(i_branch_flush), .i_branch_pc(i_branch_pc),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .o_if_valid(o_if_valid), .o_if_instr(o_if_instr), .o_if_pc(o_if_pc),
      .i_id_ready(i_id_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   // reference model: decode-visible queue plus fetch bookkeeping
   ent_t        q[$];
   logic [31:0] pc_m, pend_m, mem_addr;
   bit          run_m, busy, stale;
   int          mem_cnt;
   int          n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit req_m();
      return run_m && !busy && (q.size() < DEPTH);
   endfunction

   task automatic model_reset();
      q.delete();
      pc_m  = RESET_PC;
      run_m = 0;
      busy  = 0;
      stale = 0;
   endtask

   // one clock: check outputs at the negedge, drive inputs, advance model, wait next negedge
   task automatic cycle(input bit flush, input logic [31:0] tgt, input bit rdy,
                        input bit gnt, input int dly, input bit junk_rv);
      bit rv, req_e, granted;
      req_e = req_m();
      chk("req", o_imem_req, req_e);
      chk("valid", o_if_valid, q.size() != 0);
      if (req_e) chk("addr", o_imem_addr, pc_m);
      if (q.size() != 0) begin
         chk("head_pc", o_if_pc, q[0].pc);
         chk("head_instr", o_if_instr, q[0].instr);
      end
      rv = 0;
      if (busy) begin
         mem_cnt--;
         if (mem_cnt == 0) rv = 1;
      end else if (junk_rv) rv = 1;
      granted        = req_e && gnt;
      i_branch_flush = flush;
      i_branch_pc    = tgt;
      i_id_ready     = rdy;
      i_imem_gnt     = gnt;
      i_imem_rvalid  = rv;
      i_imem_rdata   = (busy && rv) ? (mem_addr ^ K) : $urandom();
      if (flush) q.delete();
      else if (q.size() != 0 && rdy) void'(q.pop_front());
      if (busy && rv) begin
         if (!flush && !stale) q.push_back('{pc: pend_m, instr: pend_m ^ K});
         busy = 0;
      end else if (busy && flush) stale = 1;
      if (granted) begin
         busy     = 1;
         stale    = flush;
         pend_m   = pc_m;
         mem_addr = o_imem_addr;
         mem_cnt  = dly;
      end
      if (flush) pc_m = tgt & ~32'h3;
      else if (granted) pc_m = pc_m + 32'd4;
      run_m = 1;
      @(negedge clk);
   endtask

   task automatic grant_next(input int dly);
      int n = 0;
      while (!req_m() && n < 20) begin
         cycle(0, 0, 1, 0, 1, 0);
         n++;
      end
      chk("grant_timeout", {31'b0, req_m()}, 1);
      cycle(0, 0, 1, 1, dly, 0);
   endtask

   initial begin
      int first;
      rst_n = 0;
      i_branch_flush = 0; i_branch_pc = 0; i_imem_gnt = 0;
      i_imem_rvalid = 0; i_imem_rdata = 0; i_id_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req", o_imem_req, 0);
      chk("rst_valid", o_if_valid, 0);
      chk("rst_instr", o_if_instr, 0);
      chk("rst_pc", o_if_pc, 0);
      chk("rst_addr", o_imem_addr, RESET_PC);
      rst_n = 1;

      // sequential fetch, single-cycle memory
      first = -1;
      for (int k = 0; k < 12; k++) begin
         if (first < 0 && o_if_valid) first = k;
         cycle(0, 0, 1, 1, 1, 0);
      end
      chk("first_valid_lat", first, 3);

      // backpressure: FIFO fills with 0x0, 0x4 and stops requesting
      cycle(1, 32'h0, 1, 0, 1, 0);
      repeat (10) cycle(0, 0, 0, 1, 1, 0);
      chk("bp_head", o_if_pc, 32'h0);
      chk("bp_req", o_imem_req, 0);
      repeat (10) cycle(0, 0, 1, 1, 1, 0);

      // flush while waiting for read data
      grant_next(3);
      cycle(1, 32'h200, 1, 0, 1, 0);
      repeat (8) cycle(0, 0, 1, 1, 1, 0);

      // flush coincident with grant (and a pop)
      while (!req_m()) cycle(0, 0, 1, 0, 1, 0);
      cycle(1, 32'h100, 1, 1, 2, 0);
      repeat (8) cycle(0, 0, 1, 1, 1, 0);

      // flush coincident with rvalid
      grant_next(1);
      cycle(1, 32'h40, 1, 0, 1, 0);
      repeat (6) cycle(0, 0, 1, 1, 1, 0);

      // unaligned target near the top of the address space, PC wraps to 0
      cycle(1, 32'hFFFF_FFF9, 1, 0, 1, 0);
      repeat (12) cycle(0, 0, 1, 1, 1, 0);

      // async reset mid-WAIT with one buffered entry
      cycle(1, 32'h300, 1, 0, 1, 0);
      for (int n = 0; n < 20 && !(q.size() == 1 && busy); n++)
         cycle(0, 0, 0, (q.size() == 0) || (q.size() == 1 && !busy), (q.size() == 0) ? 1 : 3, 0);
      chk("pre_rst_state", {30'b0, busy, q.size() == 1}, 3);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_req", o_imem_req, 0);
      chk("mid_rst_valid", o_if_valid, 0);
      chk("mid_rst_instr", o_if_instr, 0);
      chk("mid_rst_pc", o_if_pc, 0);
      chk("mid_rst_addr", o_imem_addr, RESET_PC);
      i_imem_gnt = 0; i_imem_rvalid = 0; i_branch_flush = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1;
      cycle(0, 0, 1, 0, 1, 1);
      repeat (8) cycle(0, 0, 1, 1, 1, 0);

      // random traffic
      repeat (2000)
         cycle($urandom_range(15) == 0, $urandom(), $urandom_range(3) != 0,
               $urandom_range(1) == 1, $urandom_range(3, 1), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
